// File: rtl/hazard_ctrl_pkg.sv
// Shared encodings for the hazard controller: opcode/funct values, Tuse/Tnew
// codes, bypass select values, mult/div latency defaults and compare helpers.
package hazard_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MTHI  = 6'h11;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MTLO  = 6'h13;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1a;
    localparam logic [5:0] FN_DIVU  = 6'h1b;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;

    typedef logic [1:0] tuse_t;
    typedef logic [1:0] tnew_t;

    // TUSE_NONE marks an operand that is not read; it never compares below any Tnew.
    localparam tuse_t TUSE_0    = 2'd0;
    localparam tuse_t TUSE_1    = 2'd1;
    localparam tuse_t TUSE_2    = 2'd2;
    localparam tuse_t TUSE_NONE = 2'd3;

    localparam tnew_t TNEW_0 = 2'd0;
    localparam tnew_t TNEW_1 = 2'd1;
    localparam tnew_t TNEW_2 = 2'd2;

    // Selects count stages ahead of the consumer: D takes E=1/M=2, E takes M=1/W=2.
    localparam logic [1:0] FWD_RF   = 2'd0;
    localparam logic [1:0] FWD_E    = 2'd1;
    localparam logic [1:0] FWD_M    = 2'd2;
    localparam logic [1:0] FWD_EX_M = 2'd1;
    localparam logic [1:0] FWD_W    = 2'd2;

    localparam int MULT_CYC_DEF = 5;
    localparam int DIV_CYC_DEF  = 10;

    // Consumer needs the value sooner than the producer can deliver it.
    function automatic logic stall_hit(input logic [4:0] src, input tuse_t tuse,
                                       input logic [4:0] dst, input tnew_t tnew);
        return (src != 5'd0) && (src == dst) && (tuse < tnew);
    endfunction

    // Producer already holds the result in its pipeline register.
    function automatic logic fwd_hit(input logic [4:0] src, input logic [4:0] dst,
                                     input tnew_t tnew);
        return (src != 5'd0) && (src == dst) && (tnew == TNEW_0);
    endfunction

endpackage

// File: rtl/instr_class_dec.sv
// Classifies one instruction word into source/destination registers and
// Tuse/Tnew codes. Mult/div group decoded only with HAZARD_MD_UNIT_EN defined.
module instr_class_dec
    import hazard_ctrl_pkg::*;
(
    input  logic [31:0] ir,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  dst,
    output tuse_t       tuse_rs,
    output tuse_t       tuse_rt,
    output tnew_t       tnew_e,
    output logic        is_md,
    output logic        is_mult,
    output logic        is_div
);

    logic [5:0] op;
    logic [5:0] fn;
    logic       unused_shamt;

    assign op           = ir[31:26];
    assign fn           = ir[5:0];
    assign unused_shamt = ^ir[10:6];

    // Unread operands report register 0 so they can never hazard or forward.
    always_comb begin
        rs      = 5'd0;
        rt      = 5'd0;
        dst     = 5'd0;
        tuse_rs = TUSE_NONE;
        tuse_rt = TUSE_NONE;
        tnew_e  = TNEW_0;
        is_md   = 1'b0;
        is_mult = 1'b0;
        is_div  = 1'b0;
        case (op)
            OP_RTYPE: begin
                case (fn)
                    FN_ADDU, FN_SUBU: begin
                        rs = ir[25:21]; tuse_rs = TUSE_1;
                        rt = ir[20:16]; tuse_rt = TUSE_1;
                        dst = ir[15:11]; tnew_e = TNEW_1;
                    end
                    FN_JR: begin
                        rs = ir[25:21]; tuse_rs = TUSE_0;
                    end
`ifdef HAZARD_MD_UNIT_EN
                    FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: begin
                        rs = ir[25:21]; tuse_rs = TUSE_1;
                        rt = ir[20:16]; tuse_rt = TUSE_1;
                        is_md   = 1'b1;
                        is_mult = (fn == FN_MULT) || (fn == FN_MULTU);
                        is_div  = (fn == FN_DIV) || (fn == FN_DIVU);
                    end
                    FN_MFHI, FN_MFLO: begin
                        dst = ir[15:11]; tnew_e = TNEW_1; is_md = 1'b1;
                    end
                    FN_MTHI, FN_MTLO: begin
                        rs = ir[25:21]; tuse_rs = TUSE_1; is_md = 1'b1;
                    end
`endif
                    default: ;
                endcase
            end
            OP_ORI: begin
                rs = ir[25:21]; tuse_rs = TUSE_1;
                dst = ir[20:16]; tnew_e = TNEW_1;
            end
            OP_LUI: begin
                dst = ir[20:16]; tnew_e = TNEW_1;
            end
            OP_LW: begin
                rs = ir[25:21]; tuse_rs = TUSE_1;
                dst = ir[20:16]; tnew_e = TNEW_2;
            end
            OP_SW: begin
                rs = ir[25:21]; tuse_rs = TUSE_1;
                rt = ir[20:16]; tuse_rt = TUSE_2;
            end
            OP_BEQ: begin
                rs = ir[25:21]; tuse_rs = TUSE_0;
                rt = ir[20:16]; tuse_rt = TUSE_0;
            end
            OP_JAL: begin
                dst = 5'd31; tnew_e = TNEW_0;
            end
            OP_J: ;
            default: ;
        endcase
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush/bypass controller for the five-stage pipeline with a busy
// counter for the mult/div unit. Define HAZARD_MD_UNIT_EN to build the
// mult/div decode, counter and md stall; otherwise md_start/md_busy are 0.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MULT_CYC = MULT_CYC_DEF,
    parameter int DIV_CYC  = DIV_CYC_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] IRD,
    input  logic [31:0] IRE,
    input  logic [31:0] IRM,
    input  logic [31:0] IRW,
    output logic        enPC,
    output logic        enD,
    output logic        FlushE,
    output logic [1:0]  fwd_d_rs,
    output logic [1:0]  fwd_d_rt,
    output logic [1:0]  fwd_e_rs,
    output logic [1:0]  fwd_e_rt,
    output logic        fwd_m_rt,
    output logic        md_start,
    output logic        md_busy
);

    logic [4:0] rs_d, rt_d, dst_d, rs_e, rt_e, dst_e;
    logic [4:0] rs_m, rt_m, dst_m, rs_w, rt_w, dst_w;
    tuse_t      tuse_rs_d, tuse_rt_d, tuse_rs_e, tuse_rt_e;
    tuse_t      tuse_rs_m, tuse_rt_m, tuse_rs_w, tuse_rt_w;
    tnew_t      tnew_e_d, tnew_e_e, tnew_e_m, tnew_e_w, tnew_m;
    logic       is_md_d, is_md_e, is_md_m, is_md_w;
    logic       is_mult_d, is_mult_e, is_mult_m, is_mult_w;
    logic       is_div_d, is_div_e, is_div_m, is_div_w;
    logic       lu_stall, stall;
    logic       unused_sig;

    instr_class_dec u_dec_d (.ir(IRD), .rs(rs_d), .rt(rt_d), .dst(dst_d),
        .tuse_rs(tuse_rs_d), .tuse_rt(tuse_rt_d), .tnew_e(tnew_e_d),
        .is_md(is_md_d), .is_mult(is_mult_d), .is_div(is_div_d));
    instr_class_dec u_dec_e (.ir(IRE), .rs(rs_e), .rt(rt_e), .dst(dst_e),
        .tuse_rs(tuse_rs_e), .tuse_rt(tuse_rt_e), .tnew_e(tnew_e_e),
        .is_md(is_md_e), .is_mult(is_mult_e), .is_div(is_div_e));
    instr_class_dec u_dec_m (.ir(IRM), .rs(rs_m), .rt(rt_m), .dst(dst_m),
        .tuse_rs(tuse_rs_m), .tuse_rt(tuse_rt_m), .tnew_e(tnew_e_m),
        .is_md(is_md_m), .is_mult(is_mult_m), .is_div(is_div_m));
    instr_class_dec u_dec_w (.ir(IRW), .rs(rs_w), .rt(rt_w), .dst(dst_w),
        .tuse_rs(tuse_rs_w), .tuse_rt(tuse_rt_w), .tnew_e(tnew_e_w),
        .is_md(is_md_w), .is_mult(is_mult_w), .is_div(is_div_w));

    // One stage later the producer is one cycle closer to its result.
    assign tnew_m = (tnew_e_m == TNEW_0) ? TNEW_0 : tnew_t'(tnew_e_m - 2'd1);

    // Load-use style hazard against producers in E and M.
    always_comb begin
        lu_stall = stall_hit(rs_d, tuse_rs_d, dst_e, tnew_e_e)
                 | stall_hit(rt_d, tuse_rt_d, dst_e, tnew_e_e)
                 | stall_hit(rs_d, tuse_rs_d, dst_m, tnew_m)
                 | stall_hit(rt_d, tuse_rt_d, dst_m, tnew_m);
    end

    // Bypass selects: nearest producer holding a finished result wins.
    always_comb begin
        fwd_d_rs = FWD_RF;
        if (fwd_hit(rs_d, dst_e, tnew_e_e))    fwd_d_rs = FWD_E;
        else if (fwd_hit(rs_d, dst_m, tnew_m)) fwd_d_rs = FWD_M;
        fwd_d_rt = FWD_RF;
        if (fwd_hit(rt_d, dst_e, tnew_e_e))    fwd_d_rt = FWD_E;
        else if (fwd_hit(rt_d, dst_m, tnew_m)) fwd_d_rt = FWD_M;
        fwd_e_rs = FWD_RF;
        if (fwd_hit(rs_e, dst_m, tnew_m))      fwd_e_rs = FWD_EX_M;
        else if (fwd_hit(rs_e, dst_w, TNEW_0)) fwd_e_rs = FWD_W;
        fwd_e_rt = FWD_RF;
        if (fwd_hit(rt_e, dst_m, tnew_m))      fwd_e_rt = FWD_EX_M;
        else if (fwd_hit(rt_e, dst_w, TNEW_0)) fwd_e_rt = FWD_W;
        fwd_m_rt = fwd_hit(rt_m, dst_w, TNEW_0);
    end

`ifdef HAZARD_MD_UNIT_EN
    localparam int MAX_CYC = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    logic [CNT_W-1:0] md_cnt_q, md_cnt_d;

    assign md_start = (is_mult_e | is_div_e) && (md_cnt_q == '0);
    assign md_busy  = (md_cnt_q != '0);
    assign stall    = lu_stall | (is_md_d & (md_busy | md_start));

    // Load on start, then count down to idle.
    always_comb begin
        md_cnt_d = md_cnt_q;
        if (md_start)     md_cnt_d = is_div_e ? CNT_W'(DIV_CYC) : CNT_W'(MULT_CYC);
        else if (md_busy) md_cnt_d = md_cnt_q - CNT_W'(1);
    end

    // Busy counter; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) md_cnt_q <= '0;
        else        md_cnt_q <= md_cnt_d;
    end

    assign unused_sig = ^{dst_d, tnew_e_d, tnew_e_w, tuse_rs_e, tuse_rt_e, tuse_rs_m,
                          tuse_rt_m, tuse_rs_w, tuse_rt_w, rs_m, rs_w, rt_w, is_md_e,
                          is_md_m, is_md_w, is_mult_d, is_mult_m, is_mult_w, is_div_d,
                          is_div_m, is_div_w};
`else
    assign md_start = 1'b0;
    assign md_busy  = 1'b0;
    assign stall    = lu_stall;

    assign unused_sig = ^{dst_d, tnew_e_d, tnew_e_w, tuse_rs_e, tuse_rt_e, tuse_rs_m,
                          tuse_rt_m, tuse_rs_w, tuse_rt_w, rs_m, rs_w, rt_w, is_md_d,
                          is_md_e, is_md_m, is_md_w, is_mult_d, is_mult_e, is_mult_m,
                          is_mult_w, is_div_d, is_div_e, is_div_m, is_div_w, clk, rst_n,
                          (MULT_CYC == DIV_CYC)};
`endif

    assign enPC   = ~stall;
    assign enD    = ~stall;
    assign FlushE = stall;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized + directed bench for hazard_ctrl with a scoreboard queue and a
// behavioural model of operand readiness (latency arithmetic per stage).
`timescale 1ns/1ps
module tb_hazard_ctrl;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;
    localparam int NONE   = 99;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] ird = '0, ire = '0, irm = '0, irw = '0;
    logic        en_pc, en_d, flush_e, fwd_m_rt, md_start, md_busy;
    logic [1:0]  fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt;

    hazard_ctrl #(.MULT_CYC(MULT_N), .DIV_CYC(DIV_N)) dut (
        .clk(clk), .rst_n(rst_n), .IRD(ird), .IRE(ire), .IRM(irm), .IRW(irw),
        .enPC(en_pc), .enD(en_d), .FlushE(flush_e),
        .fwd_d_rs(fwd_d_rs), .fwd_d_rt(fwd_d_rt), .fwd_e_rs(fwd_e_rs),
        .fwd_e_rt(fwd_e_rt), .fwd_m_rt(fwd_m_rt), .md_start(md_start),
        .md_busy(md_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int rs; int rs_use; int rt; int rt_use; int dst; int lat; bit md; bit mul; bit dv;
    } info_t;

    typedef struct { string tag; logic [13:0] v; } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   busy_until = 0;

    // Instruction builders.
    function automatic logic [31:0] rtype(input logic [5:0] fn, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [4:0] rd);
        return {6'h00, rs, rt, rd, 5'd0, fn};
    endfunction
    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt);
        return {op, rs, rt, 16'h1234};
    endfunction

    // Spec-level view: which registers are read and when, who writes what and
    // how many cycles after entering E the result exists.
    function automatic info_t decode(input logic [31:0] ir);
        info_t x;
        logic [5:0] op, fn;
        int rs, rt, rd;
        op = ir[31:26]; fn = ir[5:0];
        rs = int'(ir[25:21]); rt = int'(ir[20:16]); rd = int'(ir[15:11]);
        x.rs = rs; x.rt = rt; x.rs_use = NONE; x.rt_use = NONE; x.dst = 0; x.lat = 0;
        x.md = 0; x.mul = 0; x.dv = 0;
        if (op == 6'h00 && (fn == 6'h21 || fn == 6'h23)) begin
            x.rs_use = 1; x.rt_use = 1; x.dst = rd; x.lat = 1;
        end else if (op == 6'h00 && fn == 6'h08) x.rs_use = 0;
        else if (op == 6'h0d) begin x.rs_use = 1; x.dst = rt; x.lat = 1; end
        else if (op == 6'h0f) begin x.dst = rt; x.lat = 1; end
        else if (op == 6'h23) begin x.rs_use = 1; x.dst = rt; x.lat = 2; end
        else if (op == 6'h2b) begin x.rs_use = 1; x.rt_use = 2; end
        else if (op == 6'h04) begin x.rs_use = 0; x.rt_use = 0; end
        else if (op == 6'h03) begin x.dst = 31; x.lat = 0; end
`ifdef HAZARD_MD_UNIT_EN
        else if (op == 6'h00 && fn >= 6'h18 && fn <= 6'h1b) begin
            x.rs_use = 1; x.rt_use = 1; x.md = 1;
            x.mul = (fn <= 6'h19); x.dv = (fn >= 6'h1a);
        end else if (op == 6'h00 && (fn == 6'h10 || fn == 6'h12)) begin
            x.dst = rd; x.lat = 1; x.md = 1;
        end else if (op == 6'h00 && (fn == 6'h11 || fn == 6'h13)) begin
            x.rs_use = 1; x.md = 1;
        end
`endif
        return x;
    endfunction

    function automatic int late(input int lat, input int stages_past_e);
        return (lat > stages_past_e) ? lat - stages_past_e : 0;
    endfunction

    function automatic bit too_soon(input int src, input int use_t, input int dst, input int t);
        return use_t != NONE && src != 0 && src == dst && use_t < t;
    endfunction

    // Stages ahead of the consumer of the nearest finished producer, 0 if none.
    function automatic int ahead(input int src, input int use_t, input int d1, input int t1,
                                 input int d2, input int t2);
        if (use_t == NONE || src == 0) return 0;
        if (d1 == src && t1 == 0) return 1;
        if (d2 == src && t2 == 0) return 2;
        return 0;
    endfunction

    task automatic step(input string tag, input logic [31:0] d, input logic [31:0] e,
                        input logic [31:0] m, input logic [31:0] w, input bit r);
        info_t id, ie, im, iw;
        int te, tm;
        bit busy, start, stall;
        exp_t x;
        @(posedge clk);
        #1;
        ird = d; ire = e; irm = m; irw = w; rst_n = r;
        id = decode(d); ie = decode(e); im = decode(m); iw = decode(w);
        te = late(ie.lat, 0); tm = late(im.lat, 1);
        if (!r) busy_until = cyc;
        busy  = cyc < busy_until;
        start = (ie.mul || ie.dv) && !busy;
        stall = too_soon(id.rs, id.rs_use, ie.dst, te) || too_soon(id.rt, id.rt_use, ie.dst, te)
             || too_soon(id.rs, id.rs_use, im.dst, tm) || too_soon(id.rt, id.rt_use, im.dst, tm)
             || (id.md && (busy || start));
        x.tag = tag;
        x.v = {!stall, !stall, stall,
               2'(ahead(id.rs, id.rs_use, ie.dst, te, im.dst, tm)),
               2'(ahead(id.rt, id.rt_use, ie.dst, te, im.dst, tm)),
               2'(ahead(ie.rs, ie.rs_use, im.dst, tm, iw.dst, 0)),
               2'(ahead(ie.rt, ie.rt_use, im.dst, tm, iw.dst, 0)),
               1'(ahead(im.rt, im.rt_use, iw.dst, 0, -1, 1)),
               start, busy};
        sb.push_back(x);
        if (r && start) busy_until = cyc + 1 + (ie.dv ? DIV_N : MULT_N);
        cyc++;
    endtask

    // Monitor: compare every presented output cycle against the scoreboard.
    initial begin
        exp_t x;
        logic [13:0] got;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                x = sb.pop_front();
                got = {en_pc, en_d, flush_e, fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt,
                       fwd_m_rt, md_start, md_busy};
                total++;
                if (got !== x.v) begin
                    bad++;
                    $display("FAIL %s cyc=%0d got=%b exp=%b", x.tag, cyc, got, x.v);
                end
            end
        end
    end

    function automatic logic [4:0] rreg();
        case ($urandom_range(0, 3))
            0: return 5'd0;
            1: return 5'd1;
            2: return 5'd2;
            default: return 5'd31;
        endcase
    endfunction

    function automatic logic [31:0] rnd_instr();
        logic [4:0] a, b, c;
        logic [5:0] md_fn [8];
        md_fn = '{6'h18, 6'h19, 6'h1a, 6'h1b, 6'h10, 6'h12, 6'h11, 6'h13};
        a = rreg(); b = rreg(); c = rreg();
        case ($urandom_range(0, 13))
            0:  return rtype(6'h21, a, b, c);
            1:  return rtype(6'h23, a, b, c);
            2:  return itype(6'h0d, a, b);
            3:  return itype(6'h0f, a, b);
            4:  return itype(6'h23, a, b);
            5:  return itype(6'h2b, a, b);
            6:  return itype(6'h04, a, b);
            7:  return itype(6'h02, a, b);
            8:  return itype(6'h03, a, b);
            9:  return rtype(6'h08, a, b, c);
            10, 11: return rtype(md_fn[$urandom_range(0, 7)], a, b, c);
            12: return 32'd0;
            default: return $urandom();
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] mflo8, mult12, div12;
        mflo8  = rtype(6'h12, 5'd0, 5'd0, 5'd8);
        mult12 = rtype(6'h18, 5'd1, 5'd2, 5'd0);
        div12  = rtype(6'h1a, 5'd1, 5'd2, 5'd0);

        step("reset", 0, 0, 0, 0, 0);
        step("idle", 0, 0, 0, 0, 1);
        step("lw_use_stall", rtype(6'h21, 5'd1, 5'd3, 5'd2), itype(6'h23, 5'd0, 5'd1), 0, 0, 1);
        step("lw_use_release", rtype(6'h21, 5'd1, 5'd3, 5'd2), 0, itype(6'h23, 5'd0, 5'd1), 0, 1);
        step("beq_fwd_m", itype(6'h04, 5'd4, 5'd0), 0, rtype(6'h21, 5'd5, 5'd6, 5'd4), 0, 1);
        step("beq_r0_nofwd", itype(6'h04, 5'd0, 5'd0), 0, rtype(6'h21, 5'd5, 5'd6, 5'd0), 0, 1);
        step("beq_stall_alu_e", itype(6'h04, 5'd4, 5'd0), rtype(6'h21, 5'd5, 5'd6, 5'd4), 0, 0, 1);
        step("jr_fwd_jal", rtype(6'h08, 5'd31, 5'd0, 5'd0), itype(6'h03, 5'd0, 5'd0), 0, 0, 1);
        step("e_m_over_w", 0, rtype(6'h21, 5'd5, 5'd0, 5'd7), rtype(6'h21, 5'd1, 5'd1, 5'd5),
             itype(6'h0d, 5'd0, 5'd5), 1);
        step("e_rt_from_w", 0, rtype(6'h21, 5'd0, 5'd6, 5'd7), 0, itype(6'h0d, 5'd0, 5'd6), 1);
        step("sw_data_w", itype(6'h2b, 5'd6, 5'd6), 0, itype(6'h2b, 5'd0, 5'd6),
             rtype(6'h21, 5'd1, 5'd1, 5'd6), 1);

        step("mult_start", mflo8, mult12, 0, 0, 1);
        for (int i = 1; i <= 7; i++) step("mult_wait", mflo8, 0, 0, 0, 1);
        step("div_start", mflo8, div12, 0, 0, 1);
        for (int i = 1; i <= 12; i++) step("div_wait", mflo8, 0, 0, 0, 1);
        step("div_rst_start", mflo8, div12, 0, 0, 1);
        step("div_rst_busy", mflo8, 0, 0, 0, 1);
        step("div_rst_abort", mflo8, 0, 0, 0, 0);
        step("div_rst_after", mflo8, 0, 0, 0, 1);
        step("div_rst_idle", mflo8, 0, 0, 0, 1);

        for (int i = 0; i < 600; i++)
            step("random", rnd_instr(), rnd_instr(), rnd_instr(), rnd_instr(),
                 ($urandom_range(0, 49) != 0));

        repeat (3) @(posedge clk);
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain left=%0d required=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
